lane_packer_16: RTL

- Serial-to-parallel front end for the 16-lane FP32 adder-tree reduction path.
- Accepts one FP32 word per cycle over a valid/ready handshake and packs 16 words into one lane vector.
- Presents the vector with a valid flag that drives the adder tree's Valid_In.
- Supports early vector termination (zero-padding) and downstream backpressure, so the tree can also be fed from a buffered consumer.

---
 rtl/lane_packer_16.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lane_packer_16.sv
// Packs NUM_LANES words from a valid/ready stream into one lane vector, with early
// termination (zero padding) and output backpressure. Optional Pad_Count via LANE_PACKER_PAD_CNT_EN.
module lane_packer_16 #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = 16
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [DATA_WIDTH-1:0]           Data_In,
  input  logic                            Valid_In,
  input  logic                            Last_In,
  output logic                            Ready_In,
  output logic [NUM_LANES*DATA_WIDTH-1:0] Data_Out,
  output logic                            Valid_Out,
  input  logic                            Ready_Out
`ifdef LANE_PACKER_PAD_CNT_EN
  ,
  output logic [4:0]                      Pad_Count
`endif
);

  localparam int CW = $clog2(NUM_LANES);
  localparam int VW = NUM_LANES * DATA_WIDTH;
  localparam logic [CW-1:0] LAST_LANE = CW'(NUM_LANES - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [VW-1:0] fill_buf;
  logic [VW-1:0] comp_vec;
  logic [VW-1:0] out_vec;
  logic          accept;
  logic          complete;
  logic          out_free;
  logic          load_out;

  assign accept   = Valid_In && Ready_In;
  assign out_free = !Valid_Out || Ready_Out;
  assign complete = accept && ((cnt == LAST_LANE) || Last_In);

  // Buffer lanes below cnt, the incoming word at cnt, zeros above it.
  always_comb begin
    comp_vec = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (CW'(k) < cnt) begin
        comp_vec[k*DATA_WIDTH +: DATA_WIDTH] = fill_buf[k*DATA_WIDTH +: DATA_WIDTH];
      end else if (CW'(k) == cnt) begin
        comp_vec[k*DATA_WIDTH +: DATA_WIDTH] = Data_In;
      end else begin
        comp_vec[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
      end
    end
  end

  // Next state and output-register load select.
  always_comb begin
    next_state = state;
    load_out   = 1'b0;
    out_vec    = comp_vec;
    case (state)
      FILL: begin
        if (complete && !out_free) begin
          next_state = PEND;
        end else begin
          next_state = FILL;
        end
        load_out = complete && out_free;
        out_vec  = comp_vec;
      end
      PEND: begin
        if (out_free) begin
          next_state = FILL;
        end else begin
          next_state = PEND;
        end
        load_out = out_free;
        out_vec  = fill_buf;
      end
      default: begin
        next_state = FILL;
        load_out   = 1'b0;
        out_vec    = comp_vec;
      end
    endcase
  end

  // State, lane counter, fill buffer and output registers.
  // Writing comp_vec on every accept leaves the padded vector in place if we stall into PEND.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= FILL;
      Ready_In  <= 1'b1;
      cnt       <= '0;
      fill_buf  <= '0;
      Data_Out  <= '0;
      Valid_Out <= 1'b0;
    end else begin
      state    <= next_state;
      Ready_In <= (next_state == FILL);
      if (accept) begin
        fill_buf <= comp_vec;
      end
      if (complete) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end
      if (load_out) begin
        Data_Out  <= out_vec;
        Valid_Out <= 1'b1;
      end else if (Ready_Out) begin
        Valid_Out <= 1'b0;
      end
    end
  end

`ifdef LANE_PACKER_PAD_CNT_EN
  logic [4:0] comp_pad;
  logic [4:0] pend_pad;
  logic [4:0] out_pad;

  assign comp_pad = 5'(NUM_LANES - 1) - 5'(cnt);
  assign out_pad  = (state == PEND) ? pend_pad : comp_pad;

  // Pad count travels with the vector through the PEND stall.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pend_pad  <= 5'd0;
      Pad_Count <= 5'd0;
    end else begin
      if (complete) begin
        pend_pad <= comp_pad;
      end
      if (load_out) begin
        Pad_Count <= out_pad;
      end
    end
  end
`else
  // No padding metadata is carried with the vector in this build.
`endif

endmodule
